// File: rtl/mem_access_pkg.sv
// mem_access_pkg: width codes shared with the load decode, FSM states and counter sizing.
package mem_access_pkg;

    localparam logic [1:0] ENC_BYTE = 2'b00;
    localparam logic [1:0] ENC_HALF = 2'b01;
    localparam logic [1:0] ENC_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// mem_access_if: execute-side op handshake, data-bus port and load-decode result bundle.
interface mem_access_if;

    logic        in_valid;
    logic        in_ready;
    logic        in_we;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        done;
    logic [31:0] rd_word;
    logic [1:0]  rd_addr_lo;
    logic [2:0]  rd_funct3;
    logic        unaligned;
    logic        bus_err;

    modport slave (
        input  in_valid, in_we, in_funct3, in_addr, in_wdata, bus_ack, bus_rdata,
        output in_ready, bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
               done, rd_word, rd_addr_lo, rd_funct3, unaligned, bus_err
    );

    modport master (
        output in_valid, in_we, in_funct3, in_addr, in_wdata, bus_ack, bus_rdata,
        input  in_ready, bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
               done, rd_word, rd_addr_lo, rd_funct3, unaligned, bus_err
    );

endinterface

// File: rtl/mem_access_store_encode.sv
// mem_access_store_encode: byte strobes, lane-shifted store data and legality of one op.
module mem_access_store_encode
    import mem_access_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] lane_data,
    output logic        illegal
);

    logic [1:0] width;

    always_comb begin
        width = funct3[1:0];
        // a store has no sign/zero choice, so funct3[2] set on a store is malformed
        illegal = (width == 2'b11) || (width == ENC_HALF && addr_lo == 2'b11)
               || (width == ENC_WORD && addr_lo != 2'b00) || (we && funct3[2]);
        wstrb = !we ? 4'b0000
              : width == ENC_BYTE ? 4'b0001 << addr_lo
              : width == ENC_HALF ? 4'b0011 << addr_lo
              : 4'b1111;
        lane_data = wdata << {addr_lo, 3'b000};
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: load/store bus-access stage with alignment check, req/ack handshake
// and ack timeout; hands the raw read word plus addr[1:0]/funct3 to the load decode.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic clk,
    input logic rst,
    mem_access_if.slave m
);

    localparam int CW = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          op_we;
    logic [1:0]    op_lo;
    logic [2:0]    op_f3;
    logic [3:0]    wstrb;
    logic [31:0]   lane_data;
    logic          illegal;
    logic          timed_out;

    mem_access_store_encode u_enc (
        .we        (m.in_we),
        .funct3    (m.in_funct3),
        .addr_lo   (m.in_addr[1:0]),
        .wdata     (m.in_wdata),
        .wstrb     (wstrb),
        .lane_data (lane_data),
        .illegal   (illegal)
    );

    // cnt holds the number of ack-less BUS cycles already spent before this one
    assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            op_we        <= 1'b0;
            op_lo        <= 2'b00;
            op_f3        <= 3'b000;
            m.in_ready   <= 1'b1;
            m.bus_req    <= 1'b0;
            m.bus_we     <= 1'b0;
            m.bus_addr   <= '0;
            m.bus_wstrb  <= 4'b0000;
            m.bus_wdata  <= '0;
            m.done       <= 1'b0;
            m.rd_word    <= '0;
            m.rd_addr_lo <= 2'b00;
            m.rd_funct3  <= 3'b000;
            m.unaligned  <= 1'b0;
            m.bus_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (m.in_valid) begin
                    m.in_ready <= 1'b0;
                    op_we      <= m.in_we;
                    op_lo      <= m.in_addr[1:0];
                    op_f3      <= m.in_funct3;
                    if (illegal) begin
                        state        <= DONE;
                        m.done       <= 1'b1;
                        m.unaligned  <= 1'b1;
                        m.rd_word    <= '0;
                        m.rd_addr_lo <= m.in_addr[1:0];
                        m.rd_funct3  <= m.in_funct3;
                    end else begin
                        state       <= BUS;
                        cnt         <= '0;
                        m.bus_req   <= 1'b1;
                        m.bus_we    <= m.in_we;
                        m.bus_addr  <= {m.in_addr[31:2], 2'b00};
                        m.bus_wstrb <= wstrb;
                        m.bus_wdata <= lane_data;
                    end
                end
                // an ack arriving on the timeout cycle still completes the op
                BUS: if (m.bus_ack || timed_out) begin
                    state        <= DONE;
                    m.bus_req    <= 1'b0;
                    m.done       <= 1'b1;
                    m.bus_err    <= !m.bus_ack;
                    m.rd_word    <= (m.bus_ack && !op_we) ? m.bus_rdata : '0;
                    m.rd_addr_lo <= op_lo;
                    m.rd_funct3  <= op_f3;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                DONE: begin
                    state       <= IDLE;
                    m.done      <= 1'b0;
                    m.unaligned <= 1'b0;
                    m.bus_err   <= 1'b0;
                    m.in_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: scoreboard bench for mem_access with a 4-cycle ack timeout.
module tb_mem_access;

    localparam int TMO = 4;

    typedef struct packed {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_at;
    } op_t;

    typedef struct packed {
        int          cyc;
        int          reqs;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] word;
        logic [1:0]  lo;
        logic [2:0]  f3;
        logic        una;
        logic        err;
        logic        ready_done;
        logic        ready_after;
        logic        done_after;
        logic [31:0] word_after;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    res_t sb[$];

    mem_access_if m ();

    mem_access #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .m   (m)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic op_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rdata, input int ack_at);
        op_t r;
        r.we = we; r.f3 = f3; r.addr = addr; r.wdata = wdata; r.rdata = rdata; r.ack_at = ack_at;
        return r;
    endfunction

    function automatic res_t model(input op_t op);
        res_t e;
        logic [1:0] lo;
        logic ill;
        e = '0;
        lo = op.addr[1:0];
        case (op.f3[1:0])
            2'b00:   ill = 1'b0;
            2'b01:   ill = (lo == 2'b11);
            2'b10:   ill = (lo != 2'b00);
            default: ill = 1'b1;
        endcase
        if (op.we && op.f3[2]) ill = 1'b1;
        e.lo = lo; e.f3 = op.f3; e.una = ill; e.ready_after = 1'b1;
        if (ill) begin
            e.cyc = 1;
            return e;
        end
        e.addr = {op.addr[31:2], 2'b00};
        e.we = op.we;
        case ({op.f3[1:0], lo})
            4'b0000: e.strb = 4'b0001;
            4'b0001: e.strb = 4'b0010;
            4'b0010: e.strb = 4'b0100;
            4'b0011: e.strb = 4'b1000;
            4'b0100: e.strb = 4'b0011;
            4'b0101: e.strb = 4'b0110;
            4'b0110: e.strb = 4'b1100;
            default: e.strb = 4'b1111;
        endcase
        if (!op.we) e.strb = 4'b0000;
        for (int i = 0; i < 4; i++)
            if (i >= int'(lo)) e.wdata[8*i +: 8] = op.wdata[8*(i-int'(lo)) +: 8];
        if (op.ack_at < 1 || op.ack_at > TMO) begin
            e.cyc = TMO + 1; e.reqs = TMO; e.err = 1'b1;
        end else begin
            e.cyc = op.ack_at + 1; e.reqs = op.ack_at;
            e.word = op.we ? 32'h0 : op.rdata;
        end
        e.word_after = e.word;
        return e;
    endfunction

    // drives one op from an idle stage, acks on cycle ack_at, returns what was seen
    task automatic do_op(input op_t op, output res_t o);
        o = '0;
        o.cyc = -1;
        m.in_valid = 1'b1; m.in_we = op.we; m.in_funct3 = op.f3;
        m.in_addr = op.addr; m.in_wdata = op.wdata; m.bus_ack = 1'b0;
        step();
        m.in_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (m.done) begin
                o.cyc = c; o.word = m.rd_word; o.lo = m.rd_addr_lo; o.f3 = m.rd_funct3;
                o.una = m.unaligned; o.err = m.bus_err; o.ready_done = m.in_ready;
                step();
                o.ready_after = m.in_ready; o.done_after = m.done; o.word_after = m.rd_word;
                break;
            end
            if (m.bus_req) begin
                if (o.reqs == 0) begin
                    o.addr = m.bus_addr; o.we = m.bus_we; o.strb = m.bus_wstrb; o.wdata = m.bus_wdata;
                end
                o.reqs++;
            end
            m.bus_ack = (c == op.ack_at);
            m.bus_rdata = op.rdata;
            step();
            m.bus_ack = 1'b0;
        end
    endtask

    task automatic test_reset();
        m.in_valid = 1'b0; m.in_we = 1'b0; m.in_funct3 = 3'b000; m.in_addr = '0;
        m.in_wdata = '0; m.bus_ack = 1'b0; m.bus_rdata = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        total++;
        if (m.in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready got=%b exp=1", m.in_ready);
        end
        total++;
        if ({m.bus_req, m.bus_we, m.bus_addr, m.bus_wstrb, m.bus_wdata} !== 70'h0) begin
            bad++; $display("FAIL reset_bus got=%h exp=0", {m.bus_req, m.bus_we, m.bus_addr, m.bus_wstrb, m.bus_wdata});
        end
        total++;
        if ({m.done, m.rd_word, m.rd_addr_lo, m.rd_funct3, m.unaligned, m.bus_err} !== 40'h0) begin
            bad++; $display("FAIL reset_result got=%h exp=0", {m.done, m.rd_word, m.rd_addr_lo, m.rd_funct3, m.unaligned, m.bus_err});
        end
    endtask

    task automatic test_stray_ack();
        m.bus_ack = 1'b1;
        m.bus_rdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 3; c++) begin
            step();
            total++;
            if ({m.done, m.bus_req, m.in_ready} !== 3'b001) begin
                bad++; $display("FAIL stray_ack cyc%0d got=%b exp=001", c, {m.done, m.bus_req, m.in_ready});
            end
        end
        m.bus_ack = 1'b0;
    endtask

    task automatic test_ops();
        op_t ops[$];
        res_t o, e;
        ops.push_back(mk(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0, 3));
        ops.push_back(mk(1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_7F00, 1));
        ops.push_back(mk(1'b0, 3'b010, 32'h0000_3001, 32'h0, 32'h0, 1));
        ops.push_back(mk(1'b1, 3'b001, 32'h0000_3003, 32'h1234, 32'h0, 1));
        ops.push_back(mk(1'b0, 3'b011, 32'h0000_3000, 32'h0, 32'h0, 1));
        ops.push_back(mk(1'b1, 3'b100, 32'h0000_3000, 32'h55, 32'h0, 1));
        ops.push_back(mk(1'b0, 3'b010, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, 0));
        ops.push_back(mk(1'b0, 3'b010, 32'h0000_5000, 32'h0, 32'hDEAD_BEEF, TMO));
        ops.push_back(mk(1'b1, 3'b001, 32'h0000_6001, 32'h0000_BEEF, 32'h0, 2));
        ops.push_back(mk(1'b0, 3'b100, 32'h0000_7003, 32'h0, 32'h1122_3344, 1));
        ops.push_back(mk(1'b1, 3'b000, 32'h0000_8000, 32'h1234_5678, 32'h0, 1));
        ops.push_back(mk(1'b0, 3'b101, 32'h0000_9001, 32'h0, 32'hA0B0_C0D0, 2));
        ops.push_back(mk(1'b1, 3'b010, 32'hFFFF_FFFC, 32'h89AB_CDEF, 32'h0, 1));
        foreach (ops[i]) begin
            sb.push_back(model(ops[i]));
            do_op(ops[i], o);
            e = sb.pop_front();
            total++;
            if (o.cyc !== e.cyc) begin
                bad++; $display("FAIL op%0d done_cycle got=%0d exp=%0d", i, o.cyc, e.cyc);
            end
            total++;
            if (o.reqs !== e.reqs) begin
                bad++; $display("FAIL op%0d req_cycles got=%0d exp=%0d", i, o.reqs, e.reqs);
            end
            total++;
            if ({o.una, o.err} !== {e.una, e.err}) begin
                bad++; $display("FAIL op%0d flags(unaligned,bus_err) got=%b exp=%b", i, {o.una, o.err}, {e.una, e.err});
            end
            total++;
            if ({o.word, o.lo, o.f3} !== {e.word, e.lo, e.f3}) begin
                bad++; $display("FAIL op%0d result(word,lo,f3) got=%h/%0d/%0d exp=%h/%0d/%0d", i, o.word, o.lo, o.f3, e.word, e.lo, e.f3);
            end
            total++;
            if ({o.ready_done, o.ready_after, o.done_after, o.word_after} !== {e.ready_done, e.ready_after, e.done_after, e.word_after}) begin
                bad++; $display("FAIL op%0d after_done(rdy,rdy+1,done+1,word+1) got=%b%b%b/%h exp=%b%b%b/%h", i,
                    o.ready_done, o.ready_after, o.done_after, o.word_after, e.ready_done, e.ready_after, e.done_after, e.word_after);
            end
            if (!e.una) begin
                total++;
                if ({o.addr, o.we, o.strb, o.wdata} !== {e.addr, e.we, e.strb, e.wdata}) begin
                    bad++; $display("FAIL op%0d bus(addr,we,strb,wdata) got=%h/%b/%b/%h exp=%h/%b/%b/%h", i,
                        o.addr, o.we, o.strb, o.wdata, e.addr, e.we, e.strb, e.wdata);
                end
            end
        end
    endtask

    task automatic test_reset_mid_bus();
        op_t op;
        res_t o, e;
        int dones = 0;
        m.in_valid = 1'b1; m.in_we = 1'b0; m.in_funct3 = 3'b010; m.in_addr = 32'h40; m.bus_ack = 1'b0;
        step();
        m.in_valid = 1'b0;
        total++;
        if (m.bus_req !== 1'b1) begin
            bad++; $display("FAIL midrst_req_before got=%b exp=1", m.bus_req);
        end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if ({m.bus_req, m.in_ready, m.done} !== 3'b010) begin
            bad++; $display("FAIL midrst_after(req,ready,done) got=%b exp=010", {m.bus_req, m.in_ready, m.done});
        end
        for (int c = 0; c < 4; c++) begin
            if (m.done) dones++;
            step();
        end
        total++;
        if (dones !== 0) begin
            bad++; $display("FAIL midrst_no_done got=%0d exp=0", dones);
        end
        op = mk(1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'h1234_5678, 1);
        sb.push_back(model(op));
        do_op(op, o);
        e = sb.pop_front();
        total++;
        if ({o.cyc, o.word, o.una, o.err} !== {e.cyc, e.word, e.una, e.err}) begin
            bad++; $display("FAIL midrst_next_op(cyc,word,una,err) got=%0d/%h/%b/%b exp=%0d/%h/%b/%b",
                o.cyc, o.word, o.una, o.err, e.cyc, e.word, e.una, e.err);
        end
    endtask

    task automatic test_back_to_back();
        int exp_cyc[$];
        logic [31:0] exp_word[$];
        int rl = 0, rises = 0, rise2 = -1, dones = 0, early = 0, ec;
        logic [31:0] addr2 = '0, ew;
        m.in_valid = 1'b1; m.in_we = 1'b0; m.in_funct3 = 3'b010; m.in_addr = 32'h100; m.bus_ack = 1'b0;
        exp_cyc.push_back(3); exp_word.push_back(32'hA5A5_0001);
        step();
        m.in_addr = 32'h204;
        exp_cyc.push_back(7); exp_word.push_back(32'h5A5A_0002);
        for (int c = 1; c <= 12; c++) begin
            if (c <= 3 && m.in_ready) early++;
            if (m.bus_req) begin
                if (rl == 0) begin
                    rises++;
                    if (rises == 2) begin
                        rise2 = c; addr2 = m.bus_addr; m.in_valid = 1'b0;
                    end
                end
                rl++;
            end else begin
                rl = 0;
            end
            if (m.done) begin
                dones++;
                if (exp_cyc.size() != 0) begin
                    ec = exp_cyc.pop_front();
                    ew = exp_word.pop_front();
                    total++;
                    if (c !== ec) begin
                        bad++; $display("FAIL b2b_done_cycle got=%0d exp=%0d", c, ec);
                    end
                    total++;
                    if (m.rd_word !== ew) begin
                        bad++; $display("FAIL b2b_word got=%h exp=%h", m.rd_word, ew);
                    end
                end
            end
            m.bus_ack = m.bus_req && rl == 2;
            m.bus_rdata = (rises == 1) ? 32'hA5A5_0001 : 32'h5A5A_0002;
            step();
        end
        m.bus_ack = 1'b0;
        m.in_valid = 1'b0;
        total++;
        if (dones !== 2) begin
            bad++; $display("FAIL b2b_done_count got=%0d exp=2", dones);
        end
        total++;
        if (rise2 !== 5 || addr2 !== 32'h204) begin
            bad++; $display("FAIL b2b_second_accept(cycle,addr) got=%0d/%h exp=5/00000204", rise2, addr2);
        end
        total++;
        if (early !== 0) begin
            bad++; $display("FAIL b2b_ready_while_busy got=%0d exp=0", early);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stray_ack();
        test_ops();
        test_reset_mid_bus();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
